// File: rtl/cam_pkg.sv
// cam_pkg: default CAM geometry, lookup-controller FSM states and the registered response record
package cam_pkg;
  localparam int CAM_WIDTH = 32;
  localparam int CAM_ADDR_WIDTH = 5;
  localparam int CAM_HEIGHT = 32;
  typedef enum logic [2:0] {IDLE, SEARCH, WAIT, WRITE, RESP} cam_ctrl_state_t;
  typedef struct packed {
    logic hit;
    logic [CAM_ADDR_WIDTH-1:0] index;
    logic alloc;
  } cam_rsp_t;
endpackage

// File: rtl/cam_free_finder.sv
// cam_free_finder: combinational lowest-index free entry search; valid_i bitmap in, free_found_o/free_index_o out
module cam_free_finder
  import cam_pkg::*;
#(
  parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
  parameter int HEIGHT = CAM_HEIGHT
) (
  input  logic [HEIGHT-1:0]     valid_i,
  output logic                  free_found_o,
  output logic [ADDR_WIDTH-1:0] free_index_o
);
  always_comb begin
    free_found_o = 1'b0;
    free_index_o = '0;
    for (int i = HEIGHT - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        free_found_o = 1'b1;
        free_index_o = ADDR_WIDTH'(i);
      end
    end
  end
endmodule

// File: rtl/cam_lookup_ctrl.sv
// cam_lookup_ctrl: client req/rsp handshake in, cam search/write ports out; search, allocate on miss (first free else round-robin), flush of tracking state
module cam_lookup_ctrl
  import cam_pkg::*;
#(
  parameter int WIDTH = CAM_WIDTH,
  parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
  parameter int HEIGHT = CAM_HEIGHT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [WIDTH-1:0]      req_key_i,
  input  logic                  req_alloc_i,
  input  logic                  flush_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_hit_o,
  output logic [ADDR_WIDTH-1:0] rsp_index_o,
  output logic                  rsp_alloc_o,
  output logic                  full_o,
  output logic                  cam_search_enable_o,
  output logic [WIDTH-1:0]      cam_search_data_o,
  input  logic                  cam_search_valid_i,
  input  logic [ADDR_WIDTH-1:0] cam_search_index_i,
  output logic                  cam_write_enable_o,
  output logic [ADDR_WIDTH-1:0] cam_write_index_o,
  output logic [WIDTH-1:0]      cam_write_data_o
);
  cam_ctrl_state_t state_q, state_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic alloc_q, alloc_d;
  logic [HEIGHT-1:0] valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic full_q;
  cam_rsp_t rsp_q, rsp_d;
  logic free_found, hit;
  logic [ADDR_WIDTH-1:0] free_index, victim;
  cam_free_finder #(.ADDR_WIDTH(ADDR_WIDTH), .HEIGHT(HEIGHT)) u_free (
    .valid_i      (valid_q),
    .free_found_o (free_found),
    .free_index_o (free_index)
  );
  assign victim = free_found ? free_index : ptr_q;
  // a CAM match on an entry we have invalidated (flush) still counts as a miss
  assign hit = cam_search_valid_i && valid_q[cam_search_index_i];
  always_comb begin
    state_d = state_q;
    key_d = key_q;
    alloc_d = alloc_q;
    valid_d = valid_q;
    ptr_d = ptr_q;
    rsp_d = rsp_q;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          valid_d = '0;
          ptr_d = '0;
        end else if (req_valid_i) begin
          state_d = SEARCH;
          key_d = req_key_i;
          alloc_d = req_alloc_i;
        end
      end
      SEARCH: state_d = WAIT;
      WAIT: begin
        state_d = (!hit && alloc_q) ? WRITE : RESP;
        rsp_d.hit = hit;
        rsp_d.index = hit ? CAM_ADDR_WIDTH'(cam_search_index_i) : '0;
        rsp_d.alloc = 1'b0;
      end
      WRITE: begin
        state_d = RESP;
        valid_d[victim] = 1'b1;
        ptr_d = free_found ? ptr_q : (ptr_q == ADDR_WIDTH'(HEIGHT - 1) ? '0 : ptr_q + ADDR_WIDTH'(1));
        rsp_d.hit = 1'b0;
        rsp_d.index = CAM_ADDR_WIDTH'(victim);
        rsp_d.alloc = 1'b1;
      end
      RESP: state_d = rsp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      key_q <= '0;
      alloc_q <= 1'b0;
      valid_q <= '0;
      ptr_q <= '0;
      full_q <= 1'b0;
      rsp_q <= '0;
    end else begin
      state_q <= state_d;
      key_q <= key_d;
      alloc_q <= alloc_d;
      valid_q <= valid_d;
      ptr_q <= ptr_d;
      full_q <= &valid_d;
      rsp_q <= rsp_d;
    end
  end
  assign req_ready_o = state_q == IDLE && !flush_i;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_hit_o = rsp_valid_o && rsp_q.hit;
  assign rsp_index_o = rsp_valid_o ? ADDR_WIDTH'(rsp_q.index) : '0;
  assign rsp_alloc_o = rsp_valid_o && rsp_q.alloc;
  assign full_o = full_q;
  assign cam_search_enable_o = state_q == SEARCH;
  assign cam_search_data_o = cam_search_enable_o ? key_q : '0;
  // a reset landing in WRITE must not leave a half-done allocation in the CAM
  assign cam_write_enable_o = state_q == WRITE && !rst_i;
  assign cam_write_index_o = cam_write_enable_o ? victim : '0;
  assign cam_write_data_o = cam_write_enable_o ? key_q : '0;
endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// tb_cam_lookup_ctrl: directed scoreboard bench for cam_lookup_ctrl with a behavioural 1-cycle CAM
module tb_cam_lookup_ctrl;
  logic clk = 1'b0, rst_i = 1'b1;
  logic req_valid_i = 1'b0, req_alloc_i = 1'b0, flush_i = 1'b0, rsp_ready_i = 1'b1;
  logic [31:0] req_key_i = '0;
  logic req_ready_o, rsp_valid_o, rsp_hit_o, rsp_alloc_o, full_o;
  logic [4:0] rsp_index_o, cam_write_index_o;
  logic cam_search_enable_o, cam_write_enable_o;
  logic [31:0] cam_search_data_o, cam_write_data_o;
  logic cam_search_valid_i = 1'b0;
  logic [4:0] cam_search_index_i = '0;
  always #5 clk = ~clk;
  cam_lookup_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_key_i(req_key_i), .req_alloc_i(req_alloc_i), .flush_i(flush_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_hit_o(rsp_hit_o),
    .rsp_index_o(rsp_index_o), .rsp_alloc_o(rsp_alloc_o), .full_o(full_o),
    .cam_search_enable_o(cam_search_enable_o), .cam_search_data_o(cam_search_data_o),
    .cam_search_valid_i(cam_search_valid_i), .cam_search_index_i(cam_search_index_i),
    .cam_write_enable_o(cam_write_enable_o), .cam_write_index_o(cam_write_index_o),
    .cam_write_data_o(cam_write_data_o)
  );
  typedef struct {
    logic hit;
    logic [4:0] index;
    logic alloc;
    int lat;
    int acc;
  } exp_t;
  exp_t sb[$];
  int vec = 0, miscomp = 0, cyc = 0, wr_cnt = 0;
  bit seen = 0;
  logic [31:0] mem [32];
  logic [31:0] cv = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miscomp++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (cam_write_enable_o) begin
      mem[cam_write_index_o] <= cam_write_data_o;
      cv[cam_write_index_o] <= 1'b1;
      wr_cnt <= wr_cnt + 1;
    end
    cam_search_valid_i <= 1'b0;
    cam_search_index_i <= '0;
    if (cam_search_enable_o)
      for (int i = 31; i >= 0; i--)
        if (cv[i] && mem[i] == cam_search_data_o) begin
          cam_search_valid_i <= 1'b1;
          cam_search_index_i <= 5'(i);
        end
  end
  always @(negedge clk) begin
    #1;
    if (!rst_i && rsp_valid_o) begin
      if (sb.size() == 0) chk("rsp_unexpected", 32'(rsp_valid_o), 0);
      else begin
        if (!seen) begin
          seen = 1;
          chk("rsp_latency", cyc - sb[0].acc, sb[0].lat);
        end
        chk("rsp_hit", 32'(rsp_hit_o), 32'(sb[0].hit));
        chk("rsp_index", 32'(rsp_index_o), 32'(sb[0].index));
        chk("rsp_alloc", 32'(rsp_alloc_o), 32'(sb[0].alloc));
        if (rsp_ready_i) begin
          void'(sb.pop_front());
          seen = 0;
        end
      end
    end
  end
  task automatic issue(input logic [31:0] k, input logic a, input logic h, input logic [4:0] ix, input logic al, input int lat);
    int n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(req_ready_o), 1);
    sb.push_back('{h, ix, al, lat, cyc});
    req_valid_i = 1'b1;
    req_key_i = k;
    req_alloc_i = a;
    @(negedge clk);
    req_valid_i = 1'b0;
    req_key_i = ~k;
    req_alloc_i = ~a;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 0);
    @(negedge clk);
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready_o), 1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 0);
    chk({tag, "_rsp_fields"}, {rsp_hit_o, rsp_alloc_o, rsp_index_o}, 0);
    chk({tag, "_full"}, 32'(full_o), 0);
    chk({tag, "_search"}, {cam_search_enable_o, 31'(cam_search_data_o)}, 0);
    chk({tag, "_write"}, {cam_write_enable_o, cam_write_index_o, 26'(cam_write_data_o)}, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d vectors, %0d miscompares", vec, miscomp);
    $fatal(1);
  end
  initial begin
    int n;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    #1 chk_idle("reset");
    issue(32'hDEADBEEF, 1, 0, 0, 1, 4);
    drain();
    chk("wr_cnt_alloc", wr_cnt, 1);
    issue(32'hDEADBEEF, 0, 1, 0, 0, 3);
    drain();
    chk("wr_cnt_hit", wr_cnt, 1);
    issue(32'h55, 0, 0, 0, 0, 3);
    drain();
    chk("wr_cnt_miss", wr_cnt, 1);
    flush_i = 1'b1;
    req_valid_i = 1'b1;
    req_key_i = 32'hDEADBEEF;
    #1 chk("flush_ready", 32'(req_ready_o), 0);
    @(negedge clk);
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    #1 chk("flush_no_accept", 32'(cam_search_enable_o), 0);
    issue(32'hDEADBEEF, 0, 0, 0, 0, 3);
    drain();
    for (int i = 0; i < 32; i++) issue(32'h100 + i, 1, 0, 5'(i), 1, 4);
    drain();
    chk("full_after_fill", 32'(full_o), 1);
    chk("wr_cnt_fill", wr_cnt, 33);
    issue(32'h200, 1, 0, 0, 1, 4);
    issue(32'h201, 1, 0, 1, 1, 4);
    issue(32'h201, 0, 1, 1, 0, 3);
    issue(32'h101, 0, 0, 0, 0, 3);
    issue(32'h102, 0, 1, 2, 0, 3);
    drain();
    chk("full_after_replace", 32'(full_o), 1);
    rsp_ready_i = 1'b0;
    issue(32'h200, 0, 1, 0, 0, 3);
    n = 0;
    while (!rsp_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_rsp_seen", 32'(rsp_valid_o), 1);
    repeat (5) begin
      chk("hold_req_ready", 32'(req_ready_o), 0);
      @(negedge clk);
    end
    rsp_ready_i = 1'b1;
    drain();
    req_valid_i = 1'b1;
    req_key_i = 32'h300;
    req_alloc_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    n = 0;
    while (!cam_write_enable_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_write_reached", 32'(cam_write_enable_o), 1);
    rst_i = 1'b1;
    #1 chk("rst_write_suppressed", 32'(cam_write_enable_o), 0);
    @(negedge clk);
    rst_i = 1'b0;
    #1 chk_idle("midreset");
    repeat (6) @(negedge clk);
    chk("rst_no_rsp", 32'(rsp_valid_o), 0);
    chk("rst_wr_cnt", wr_cnt, 35);
    issue(32'h102, 0, 0, 0, 0, 3);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscomp);
    $finish;
  end
endmodule
